// File: rtl/reg_file_if.sv
// Dispatch, commit and source-read signals between the pipeline front end and
// the renaming register file.
interface reg_file_if #(
  parameter int LAB_W = 5,
  parameter int VAL_W = 32
);
  logic             issue_en;
  logic [4:0]       issue_rd;
  logic [LAB_W-1:0] issue_lab;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [LAB_W-1:0] rf_label1;
  logic [LAB_W-1:0] rf_label2;
  logic [VAL_W-1:0] rf_val1;
  logic [VAL_W-1:0] rf_val2;
  logic             commit_en;
  logic [4:0]       commit_rd;
  logic [VAL_W-1:0] commit_res;
  logic [LAB_W-1:0] commit_lab;

  modport master (
    output issue_en, issue_rd, issue_lab, rs1, rs2,
           commit_en, commit_rd, commit_res, commit_lab,
    input  rf_label1, rf_label2, rf_val1, rf_val2
  );

  modport slave (
    input  issue_en, issue_rd, issue_lab, rs1, rs2,
           commit_en, commit_rd, commit_res, commit_lab,
    output rf_label1, rf_label2, rf_val1, rf_val2
  );
endinterface

// File: rtl/reg_file.sv
// Architectural register file with per-register rename labels. Reads are
// combinational, and a commit that is still the newest producer of a source
// register is bypassed onto that source in the same cycle.
module reg_file #(
  parameter int NREG  = 32,
  parameter int LAB_W = 5,
  parameter int VAL_W = 32
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  reg_file_if.slave   bus
);

  logic [VAL_W-1:0] value_q [NREG];
  logic [LAB_W-1:0] label_q [NREG];

  // A source takes the commit result only when the committing ROB entry
  // still owns that register's label.
  function automatic logic bypass_hit(
    input logic             c_en,
    input logic [4:0]       c_rd,
    input logic [LAB_W-1:0] c_lab,
    input logic [4:0]       rs,
    input logic [LAB_W-1:0] cur_lab
  );
    return c_en && (c_rd == rs) && (rs != 5'd0) && (cur_lab == c_lab);
  endfunction

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      for (int r = 0; r < NREG; r++) begin
        value_q[r] <= '0;
        label_q[r] <= '0;
      end
    end else if (rdy_in) begin
      if (bus.commit_en && bus.commit_rd != 5'd0) begin
        value_q[bus.commit_rd] <= bus.commit_res;
        if (label_q[bus.commit_rd] == bus.commit_lab)
          label_q[bus.commit_rd] <= '0;
      end
      // Later assignments win: flush clears every label, otherwise an issue
      // to the same register overrides the commit's label clear.
      if (flush_in) begin
        for (int r = 0; r < NREG; r++)
          label_q[r] <= '0;
      end else if (bus.issue_en && bus.issue_rd != 5'd0) begin
        label_q[bus.issue_rd] <= bus.issue_lab;
      end
    end
  end

  always_comb begin
    bus.rf_label1 = label_q[bus.rs1];
    bus.rf_val1   = value_q[bus.rs1];
    bus.rf_label2 = label_q[bus.rs2];
    bus.rf_val2   = value_q[bus.rs2];

    if (bypass_hit(bus.commit_en, bus.commit_rd, bus.commit_lab, bus.rs1, label_q[bus.rs1])) begin
      bus.rf_label1 = '0;
      bus.rf_val1   = bus.commit_res;
    end
    if (bypass_hit(bus.commit_en, bus.commit_rd, bus.commit_lab, bus.rs2, label_q[bus.rs2])) begin
      bus.rf_label2 = '0;
      bus.rf_val2   = bus.commit_res;
    end

    if (rst_in || bus.rs1 == 5'd0) begin
      bus.rf_label1 = '0;
      bus.rf_val1   = '0;
    end
    if (rst_in || bus.rs2 == 5'd0) begin
      bus.rf_label2 = '0;
      bus.rf_val2   = '0;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed vector bench for reg_file: one table row per clock cycle, with the
// read ports compared just before the edge that applies that row's writes.
module tb_reg_file;

  logic clk;
  logic rst_in;
  logic rdy_in;
  logic flush_in;

  reg_file_if #(.LAB_W(5), .VAL_W(32)) bus ();

  reg_file #(.NREG(32), .LAB_W(5), .VAL_W(32)) dut (
    .clk      (clk),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .flush_in (flush_in),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ie;
    logic [4:0]  ird;
    logic [4:0]  ilab;
    logic        ce;
    logic [4:0]  crd;
    logic [31:0] cres;
    logic [4:0]  clab;
    logic        fl;
    logic        rdy;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  el1;
    logic [31:0] ev1;
    logic [4:0]  el2;
    logic [31:0] ev2;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  int nchk;
  int nerr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_ports(input string tag, input logic [4:0] l1, input logic [31:0] v1,
                           input logic [4:0] l2, input logic [31:0] v2);
    chk({tag, " label1"}, 32'(bus.rf_label1), 32'(l1));
    chk({tag, " val1"},   bus.rf_val1,        v1);
    chk({tag, " label2"}, 32'(bus.rf_label2), 32'(l2));
    chk({tag, " val2"},   bus.rf_val2,        v2);
  endtask

  task automatic idle();
    bus.issue_en   = 1'b0;
    bus.issue_rd   = 5'd0;
    bus.issue_lab  = 5'd0;
    bus.commit_en  = 1'b0;
    bus.commit_rd  = 5'd0;
    bus.commit_res = 32'd0;
    bus.commit_lab = 5'd0;
    flush_in       = 1'b0;
    rdy_in         = 1'b1;
  endtask

  initial begin
    nchk = 0;
    nerr = 0;

    //            ie ird ilab ce crd cres           clab fl rdy rs1 rs2 el1 ev1            el2 ev2
    vecs[0]  = '{1, 5, 3,   0, 0, 32'h0,         0,   0, 1,  5,  0,  0, 32'h0,         0, 32'h0};
    vecs[1]  = '{0, 0, 0,   0, 0, 32'h0,         0,   0, 1,  5,  0,  3, 32'h0,         0, 32'h0};
    vecs[2]  = '{0, 0, 0,   1, 5, 32'h1234,      3,   0, 1,  5,  5,  0, 32'h1234,      0, 32'h1234};
    vecs[3]  = '{0, 0, 0,   0, 0, 32'h0,         0,   0, 1,  5,  0,  0, 32'h1234,      0, 32'h0};
    vecs[4]  = '{1, 7, 2,   0, 0, 32'h0,         0,   0, 1,  7,  0,  0, 32'h0,         0, 32'h0};
    vecs[5]  = '{1, 7, 9,   0, 0, 32'h0,         0,   0, 1,  7,  0,  2, 32'h0,         0, 32'h0};
    vecs[6]  = '{0, 0, 0,   1, 7, 32'hAA,        2,   0, 1,  7,  7,  9, 32'h0,         9, 32'h0};
    vecs[7]  = '{0, 0, 0,   0, 0, 32'h0,         0,   0, 1,  7,  0,  9, 32'hAA,        0, 32'h0};
    vecs[8]  = '{1, 4, 1,   0, 0, 32'h0,         0,   0, 1,  4,  0,  0, 32'h0,         0, 32'h0};
    vecs[9]  = '{1, 4, 6,   1, 4, 32'h55,        1,   0, 1,  4,  0,  0, 32'h55,        0, 32'h0};
    vecs[10] = '{0, 0, 0,   0, 0, 32'h0,         0,   0, 1,  4,  0,  6, 32'h55,        0, 32'h0};
    vecs[11] = '{1, 1, 1,   0, 0, 32'h0,         0,   0, 1,  1,  0,  0, 32'h0,         0, 32'h0};
    vecs[12] = '{1, 2, 2,   0, 0, 32'h0,         0,   0, 1,  1,  0,  1, 32'h0,         0, 32'h0};
    vecs[13] = '{1, 3, 16,  0, 0, 32'h0,         0,   0, 1,  2,  1,  2, 32'h0,         1, 32'h0};
    vecs[14] = '{1, 8, 4,   1, 2, 32'h77,        5,   1, 1,  3,  2, 16, 32'h0,         2, 32'h0};
    vecs[15] = '{0, 0, 0,   0, 0, 32'h0,         0,   0, 1,  2,  8,  0, 32'h77,        0, 32'h0};
    vecs[16] = '{0, 0, 0,   0, 0, 32'h0,         0,   0, 1,  1,  3,  0, 32'h0,         0, 32'h0};
    vecs[17] = '{1, 0, 5,   1, 0, 32'hFFFFFFFF,  0,   0, 1,  0,  0,  0, 32'h0,         0, 32'h0};
    vecs[18] = '{0, 0, 0,   0, 0, 32'h0,         0,   0, 1,  0,  0,  0, 32'h0,         0, 32'h0};
    vecs[19] = '{1, 9, 7,   1, 5, 32'h999,       0,   0, 0,  9,  5,  0, 32'h0,         0, 32'h999};
    vecs[20] = '{0, 0, 0,   0, 0, 32'h0,         0,   0, 1,  9,  5,  0, 32'h0,         0, 32'h1234};

    // Reset state, with a matching-label commit presented to prove reads stay 0.
    idle();
    rst_in = 1'b1;
    bus.rs1 = 5'd5;
    bus.rs2 = 5'd31;
    bus.commit_en  = 1'b1;
    bus.commit_rd  = 5'd5;
    bus.commit_res = 32'hDEAD;
    #12;
    chk_ports("reset", 5'd0, 32'h0, 5'd0, 32'h0);
    idle();
    @(negedge clk);
    rst_in = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.issue_en   = vecs[i].ie;
      bus.issue_rd   = vecs[i].ird;
      bus.issue_lab  = vecs[i].ilab;
      bus.commit_en  = vecs[i].ce;
      bus.commit_rd  = vecs[i].crd;
      bus.commit_res = vecs[i].cres;
      bus.commit_lab = vecs[i].clab;
      flush_in       = vecs[i].fl;
      rdy_in         = vecs[i].rdy;
      bus.rs1        = vecs[i].rs1;
      bus.rs2        = vecs[i].rs2;
      #2;
      chk_ports($sformatf("vec%0d", i), vecs[i].el1, vecs[i].ev1, vecs[i].el2, vecs[i].ev2);
    end

    // Build a pending rename on r10 and a committed value on r11.
    @(negedge clk);
    idle();
    bus.issue_en  = 1'b1;
    bus.issue_rd  = 5'd10;
    bus.issue_lab = 5'd11;
    bus.commit_en  = 1'b1;
    bus.commit_rd  = 5'd11;
    bus.commit_res = 32'h42;
    bus.commit_lab = 5'd0;
    @(negedge clk);
    idle();
    bus.rs1 = 5'd10;
    bus.rs2 = 5'd11;
    #1;
    chk_ports("pre-rst", 5'd11, 32'h0, 5'd0, 32'h42);

    // Asynchronous reset pulse well away from any posedge.
    rst_in = 1'b1;
    #1;
    chk_ports("mid-rst", 5'd0, 32'h0, 5'd0, 32'h0);
    rst_in = 1'b0;
    #1;
    chk_ports("post-rst", 5'd0, 32'h0, 5'd0, 32'h0);

    // First update after reset lands on the next enabled edge.
    @(negedge clk);
    bus.issue_en  = 1'b1;
    bus.issue_rd  = 5'd10;
    bus.issue_lab = 5'd13;
    @(negedge clk);
    idle();
    #1;
    chk("after-rst issue label1", 32'(bus.rf_label1), 32'd13);
    chk("after-rst val2",         bus.rf_val2,        32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish, expected finish before 50000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter NREG, 32, number of architectural registers.
REQ-002 The block SHALL have parameter LAB_W, 5, rename-label width; label 0 = "no pending producer", labels 1..16 = ROB entries.
REQ-003 The block SHALL have parameter VAL_W, 32, register value width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-005 The block SHALL have port rst_in, input, 1, reset, asynchronous and active-high.
REQ-006 The block SHALL have port rdy_in, input, 1, global enable; when low, no state update.
REQ-007 The block SHALL have port flush_in, input, 1, misprediction flush from the ROB.
REQ-008 The block SHALL have ports issue_en (input, 1), issue_rd (input, 5) and issue_lab (input, LAB_W): decoder dispatch renaming rd to a ROB label.
REQ-009 The block SHALL have ports rs1 and rs2, input, 5 each, source register read addresses.
REQ-010 The block SHALL have ports rf_label1 and rf_label2, output, LAB_W each, pending label per source; 0 means the value is final.
REQ-011 The block SHALL have ports rf_val1 and rf_val2, output, VAL_W each, architectural value per source.
REQ-012 The block SHALL have ports commit_en (input, 1), commit_rd (input, 5), commit_res (input, VAL_W) and commit_lab (input, LAB_W): the ROB commit write.

Function
REQ-013 Per register, the block SHALL hold value[r] (VAL_W) and label[r] (LAB_W).
REQ-014 x0: reads SHALL return value 0 and label 0; issue and commit writes to rd=0 SHALL be ignored.
REQ-015 Reads SHALL be combinational, with zero latency: rf_labelN = label[rsN], rf_valN = value[rsN].
REQ-016 Commit bypass: if commit_en && commit_rd==rsN && rsN!=0 && label[rsN]==commit_lab, the block SHALL drive rf_labelN=0 and rf_valN=commit_res in the same cycle.
REQ-017 Commit bypass SHALL apply regardless of rdy_in.
REQ-018 Issue SHALL NOT bypass to reads in the same cycle; a dispatched instruction sees the pre-issue label.
REQ-019 Commit (posedge, rdy_in=1, commit_en=1, commit_rd!=0): the block SHALL set value[commit_rd] <= commit_res.
REQ-020 On the same commit, the block SHALL clear label[commit_rd] <= 0 only if label[commit_rd]==commit_lab; otherwise the label SHALL be kept, because a younger producer owns it.
REQ-021 Issue (posedge, rdy_in=1, issue_en=1, issue_rd!=0, flush_in=0): the block SHALL set label[issue_rd] <= issue_lab.
REQ-022 When issue and commit hit the same rd in one cycle, the value SHALL take commit_res and the label SHALL take issue_lab (issue wins over clear).
REQ-023 Flush (posedge, rdy_in=1, flush_in=1): the block SHALL set every label <= 0 and leave values unchanged.
REQ-024 A commit in the flush cycle SHALL still write its value; an issue in the flush cycle SHALL be discarded.
REQ-025 rdy_in=0: the block SHALL freeze all state; issue, commit and flush are lost (upstream holds them).
REQ-026 Label values SHALL be stored as given; no wrap arithmetic is performed here, and label 16 is a valid nonzero label.

Reset
REQ-027 While rst_in=1 (asynchronous, independent of clk and rdy_in), every value[r] SHALL be 0 and every label[r] SHALL be 0.
REQ-028 During reset, outputs SHALL read rf_label1/2=0 and rf_val1/2=0 for any rs.
REQ-029 Reset asserted mid-operation SHALL discard all pending renames immediately.
REQ-030 The first update after reset deasserts SHALL occur on the next posedge with rdy_in=1.

Verification
REQ-031 Bench SHALL cover: issue rd=5 lab=3; next cycle rs1=5 -> rf_label1=3. Commit rd=5 res=0x1234 lab=3 -> same cycle rf_label1=0, rf_val1=0x1234; after edge label[5]=0, value[5]=0x1234.
REQ-032 Bench SHALL cover: issue rd=7 lab=2, then issue rd=7 lab=9; commit rd=7 lab=2 res=0xAA -> value[7]=0xAA, label[7] stays 9, rf_label=9, no bypass.
REQ-033 Bench SHALL cover: same cycle issue rd=4 lab=6 and commit rd=4 lab=1 (label[4] was 1) res=0x55 -> value[4]=0x55, label[4]=6.
REQ-034 Bench SHALL cover: labels pending on r1, r2, r3; flush_in=1 with commit rd=2 res=0x77 and issue rd=8 lab=4 -> all labels 0, value[2]=0x77, label[8]=0.
REQ-035 Bench SHALL cover: issue/commit to rd=0 with res=0xFFFFFFFF -> rs1=0 reads label 0, value 0; rdy_in=0 with an issue of rd=9 -> label[9] unchanged.
REQ-036 Bench SHALL cover: rst_in pulsed between clock edges with labels pending -> all labels and values read 0 before the next posedge.
